// File: rtl/dtlb.sv
// Fully-associative data TLB: one-cycle lookup for the memory stage,
// software-refilled through a round-robin fill port, cleared by flush.
module dtlb #(
  parameter int ENTRIES   = 4,
  parameter int PAGE_BITS = 12
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  input  logic [31:0]            req_vaddr,
  input  logic                   supervisor,
  output logic                   dtlb_ready,
  output logic                   dtlb_miss,
  output logic [31:0]            resp_paddr,
  output logic [31:0]            resp_vaddr,
  input  logic                   fill_valid,
  input  logic [31-PAGE_BITS:0]  fill_vpn,
  input  logic [31-PAGE_BITS:0]  fill_ppn,
  input  logic                   flush,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);

  localparam int VPN_W = 32 - PAGE_BITS;
  localparam int PTR_W = $clog2(ENTRIES);

  logic [VPN_W-1:0]   vpn [ENTRIES];
  logic [VPN_W-1:0]   ppn [ENTRIES];
  logic [ENTRIES-1:0] valid;
  logic [PTR_W-1:0]   ptr;

  logic [VPN_W-1:0]   req_vpn;
  logic [ENTRIES-1:0] req_match;
  logic               hit;
  logic [VPN_W-1:0]   hit_ppn;
  logic [ENTRIES-1:0] fill_match;
  logic               fill_hit;
  logic [PTR_W-1:0]   fill_idx;

  assign req_vpn = req_vaddr[31:PAGE_BITS];

  // Match vectors and lowest-index priority select for lookup and fill.
  always_comb begin
    hit_ppn  = '0;
    fill_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      req_match[i]  = valid[i] && (vpn[i] == req_vpn);
      fill_match[i] = valid[i] && (vpn[i] == fill_vpn);
    end
    // Descending scan so the lowest matching index is the final writer.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      hit_ppn  = req_match[i]  ? ppn[i]       : hit_ppn;
      fill_idx = fill_match[i] ? PTR_W'(i)    : fill_idx;
    end
    hit      = |req_match;
    fill_hit = |fill_match;
  end

  // Table contents and replacement pointer; flush takes priority over fill.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      ptr   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        vpn[i] <= '0;
        ppn[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
      ptr   <= '0;
    end else if (fill_valid) begin
      if (fill_hit) begin
        ppn[fill_idx] <= fill_ppn;
      end else begin
        vpn[ptr]   <= fill_vpn;
        ppn[ptr]   <= fill_ppn;
        valid[ptr] <= 1'b1;
        ptr        <= ptr + PTR_W'(1);
      end
    end else begin
      valid <= valid;
    end
  end

  // Registered response and saturating hit/miss statistics.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dtlb_ready <= 1'b0;
      dtlb_miss  <= 1'b0;
      resp_paddr <= 32'h0000_0000;
      resp_vaddr <= 32'h0000_0000;
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      dtlb_ready <= req_valid;
      dtlb_miss  <= req_valid && !supervisor && !hit;
      if (!req_valid) begin
        resp_paddr <= 32'h0000_0000;
      end else if (supervisor) begin
        resp_paddr <= req_vaddr;
      end else if (hit) begin
        resp_paddr <= {hit_ppn, req_vaddr[PAGE_BITS-1:0]};
      end else begin
        resp_paddr <= 32'h0000_0000;
      end
      if (req_valid) begin
        resp_vaddr <= req_vaddr;
      end else begin
        resp_vaddr <= resp_vaddr;
      end
      if (req_valid && !supervisor && hit && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'h0001;
      end else begin
        hit_count <= hit_count;
      end
      if (req_valid && !supervisor && !hit && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'h0001;
      end else begin
        miss_count <= miss_count;
      end
    end
  end

endmodule

// File: tb/tb_dtlb.sv
// Directed self-checking bench for dtlb (ENTRIES=4, PAGE_BITS=12).
module tb_dtlb;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        supervisor;
  logic        dtlb_ready;
  logic        dtlb_miss;
  logic [31:0] resp_paddr;
  logic [31:0] resp_vaddr;
  logic        fill_valid;
  logic [19:0] fill_vpn;
  logic [19:0] fill_ppn;
  logic        flush;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int errors = 0;
  int checks = 0;

  dtlb #(.ENTRIES(4), .PAGE_BITS(12)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_vaddr  (req_vaddr),
    .supervisor (supervisor),
    .dtlb_ready (dtlb_ready),
    .dtlb_miss  (dtlb_miss),
    .resp_paddr (resp_paddr),
    .resp_vaddr (resp_vaddr),
    .fill_valid (fill_valid),
    .fill_vpn   (fill_vpn),
    .fill_ppn   (fill_ppn),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic look(input logic [31:0] addr, input logic sup);
    req_valid  = 1'b1;
    req_vaddr  = addr;
    supervisor = sup;
    cycle();
    req_valid  = 1'b0;
    supervisor = 1'b0;
  endtask

  task automatic fill(input logic [19:0] v, input logic [19:0] p);
    fill_valid = 1'b1;
    fill_vpn   = v;
    fill_ppn   = p;
    cycle();
    fill_valid = 1'b0;
  endtask

  task automatic resp(input string tag, input logic miss, input logic [31:0] pa, input logic [31:0] va);
    chk({tag, ".ready"}, dtlb_ready, 1'b1);
    chk({tag, ".miss"},  dtlb_miss, miss);
    chk({tag, ".paddr"}, resp_paddr, pa);
    chk({tag, ".vaddr"}, resp_vaddr, va);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_vaddr = 32'h0; supervisor = 1'b0;
    fill_valid = 1'b0; fill_vpn = 20'h0; fill_ppn = 20'h0; flush = 1'b0;
    cycle(); cycle();
    chk("rst.ready", dtlb_ready, 1'b0);
    chk("rst.miss",  dtlb_miss, 1'b0);
    chk("rst.paddr", resp_paddr, 32'h0);
    chk("rst.vaddr", resp_vaddr, 32'h0);
    chk("rst.hits",  hit_count, 16'h0);
    chk("rst.misses", miss_count, 16'h0);
    reset_n = 1'b1;
    cycle();

    // Cold miss
    look(32'h0000_5ABC, 1'b0);
    resp("cold", 1'b1, 32'h0, 32'h0000_5ABC);
    chk("cold.misses", miss_count, 16'd1);
    cycle();
    chk("idle.ready", dtlb_ready, 1'b0);
    chk("idle.miss",  dtlb_miss, 1'b0);

    // Fill then hit
    fill(20'h00005, 20'h00123);
    look(32'h0000_5ABC, 1'b0);
    resp("hit5", 1'b0, 32'h0012_3ABC, 32'h0000_5ABC);
    chk("hit5.hits", hit_count, 16'd1);

    // Fill and request same VPN at same edge: pre-fill contents
    fill_valid = 1'b1; fill_vpn = 20'h00007; fill_ppn = 20'h000AA;
    look(32'h0000_7123, 1'b0);
    fill_valid = 1'b0;
    resp("samefill", 1'b1, 32'h0, 32'h0000_7123);
    chk("samefill.misses", miss_count, 16'd2);
    look(32'h0000_7123, 1'b0);
    resp("afterfill", 1'b0, 32'h000A_A123, 32'h0000_7123);
    chk("afterfill.hits", hit_count, 16'd2);

    // Flush with request at same edge uses pre-flush contents
    flush = 1'b1;
    look(32'h0000_5ABC, 1'b0);
    flush = 1'b0;
    resp("flushsame", 1'b0, 32'h0012_3ABC, 32'h0000_5ABC);
    look(32'h0000_5ABC, 1'b0);
    resp("postflush", 1'b1, 32'h0, 32'h0000_5ABC);
    chk("postflush.misses", miss_count, 16'd3);

    // Flush wins over fill at the same edge
    flush = 1'b1;
    fill(20'h00009, 20'h00001);
    flush = 1'b0;
    look(32'h0000_9000, 1'b0);
    resp("flushfill", 1'b1, 32'h0, 32'h0000_9000);

    // Five fills into four entries: VPN 0x10 evicted, pointer back at 1
    for (int k = 0; k < 5; k++) fill(20'h00010 + 20'(k), 20'h00100 + 20'(k));
    look(32'h0001_0345, 1'b0);
    resp("evicted", 1'b1, 32'h0, 32'h0001_0345);
    look(32'h0001_1345, 1'b0);
    resp("keep11", 1'b0, 32'h0010_1345, 32'h0001_1345);
    look(32'h0001_4345, 1'b0);
    resp("keep14", 1'b0, 32'h0010_4345, 32'h0001_4345);
    chk("evict.hits",   hit_count, 16'd5);
    chk("evict.misses", miss_count, 16'd5);

    // Re-fill existing VPN: PPN replaced, pointer untouched (next new fill evicts 0x11)
    fill(20'h00012, 20'h001FF);
    fill(20'h00015, 20'h00105);
    look(32'h0001_2345, 1'b0);
    resp("refill12", 1'b0, 32'h001F_F345, 32'h0001_2345);
    look(32'h0001_3345, 1'b0);
    resp("keep13", 1'b0, 32'h0010_3345, 32'h0001_3345);
    look(32'h0001_1345, 1'b0);
    resp("evict11", 1'b1, 32'h0, 32'h0001_1345);
    look(32'h0001_5345, 1'b0);
    resp("new15", 1'b0, 32'h0010_5345, 32'h0001_5345);
    look(32'h0001_4345, 1'b0);
    resp("still14", 1'b0, 32'h0010_4345, 32'h0001_4345);

    // Supervisor bypass
    look(32'hDEAD_BEEF, 1'b1);
    resp("super", 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk("super.hits",   hit_count, 16'd9);
    chk("super.misses", miss_count, 16'd6);

    // Flush: everything misses
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int k = 2; k < 6; k++) begin
      look({20'h00010 + 20'(k), 12'h345}, 1'b0);
      chk("flushall.miss", dtlb_miss, 1'b1);
    end
    chk("flushall.misses", miss_count, 16'd10);

    // Asynchronous reset while a response is showing
    look(32'h1234_5678, 1'b0);
    chk("inflight.ready", dtlb_ready, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async.ready",  dtlb_ready, 1'b0);
    chk("async.vaddr",  resp_vaddr, 32'h0);
    chk("async.misses", miss_count, 16'h0);
    #1 reset_n = 1'b1;
    cycle();
    chk("release.ready", dtlb_ready, 1'b0);
    cycle();
    chk("release2.ready", dtlb_ready, 1'b0);
    look(32'h0001_5345, 1'b0);
    resp("afterrst", 1'b1, 32'h0, 32'h0001_5345);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
